// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: takes raw counters and syncs from the timing
// stage, renders one of four patterns (colour bars, grid, bouncing box, solid
// grey) and emits RGB plus delayed syncs on a two-stage pipeline.
// Mode changes and box movement are committed only on the frame-start pulse,
// so each frame is drawn with a single, consistent mode and box position.
module vga_pattern_gen #(
    parameter int BOX_SIZE = 32,
    parameter int BOX_STEP = 2
) (
    input  logic       clk_25,
    input  logic       reset,
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    input  logic       bright,
    input  logic       h_sync_in,
    input  logic       v_sync_in,
    input  logic       mode_next,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       h_sync,
    output logic       v_sync,
    output logic       frame_tick
);

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_GRID  = 2'd1,
        MODE_BOX   = 2'd2,
        MODE_SOLID = 2'd3
    } mode_t;

    localparam logic [9:0]  H_START = 10'd160;
    localparam logic [9:0]  V_START = 10'd41;
    localparam logic [9:0]  X_LIMIT = 10'(640 - BOX_SIZE);
    localparam logic [9:0]  Y_LIMIT = 10'(480 - BOX_SIZE);
    localparam logic [9:0]  STEP    = 10'(BOX_STEP);
    localparam logic [10:0] SIZE    = 11'(BOX_SIZE);

    // Advance one box axis by STEP; reaching or passing a limit clamps to
    // that limit and flips the direction in the same update.
    // Result is {new_dir, new_pos}; dir 1 means increasing.
    function automatic logic [10:0] step_axis(input logic [9:0] pos,
                                              input logic       dir,
                                              input logic [9:0] lim);
        logic [10:0] res;
        if (dir) begin
            if (({1'b0, pos} + {1'b0, STEP}) >= {1'b0, lim}) begin
                res = {1'b0, lim};
            end else begin
                res = {1'b1, pos + STEP};
            end
        end else begin
            if (pos <= STEP) begin
                res = {1'b1, 10'd0};
            end else begin
                res = {1'b0, pos - STEP};
            end
        end
        return res;
    endfunction

    // Colour of the eight 80-pixel vertical bars.
    function automatic logic [11:0] bar_colour(input logic [9:0] x);
        logic [11:0] c;
        if (x < 10'd80) begin
            c = 12'hFFF;
        end else if (x < 10'd160) begin
            c = 12'hFF0;
        end else if (x < 10'd240) begin
            c = 12'h0FF;
        end else if (x < 10'd320) begin
            c = 12'h0F0;
        end else if (x < 10'd400) begin
            c = 12'hF0F;
        end else if (x < 10'd480) begin
            c = 12'hF00;
        end else if (x < 10'd560) begin
            c = 12'h00F;
        end else begin
            c = 12'h000;
        end
        return c;
    endfunction

    // Stage 1 registers
    logic [9:0]  x_q, y_q;
    logic        bright_q, hs1_q, vs1_q;
    // Stage 2 registers
    logic [11:0] rgb_q;
    logic        hs2_q, vs2_q;
    // Frame state
    logic        frame_tick_q;
    mode_t       mode_q, mode_d;
    logic        pending_q, pending_d;
    logic [9:0]  bx_q, bx_d, by_q, by_d;
    logic        dx_q, dx_d, dy_q, dy_d;
    logic [11:0] rgb_s;
    logic        in_box_s;

    // Stage 1: capture timing inputs and translate counters to active-area x/y.
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            x_q      <= 10'd0;
            y_q      <= 10'd0;
            bright_q <= 1'b0;
            hs1_q    <= 1'b1;
            vs1_q    <= 1'b1;
        end else begin
            x_q      <= h_count - H_START;
            y_q      <= v_count - V_START;
            bright_q <= bright;
            hs1_q    <= h_sync_in;
            vs1_q    <= v_sync_in;
        end
    end

    // Frame-start pulse: one cycle after counter origin is sampled.
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= (h_count == 10'd0) && (v_count == 10'd0);
        end
    end

    // Mode FSM and box state register.
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            mode_q    <= MODE_BARS;
            pending_q <= 1'b0;
            bx_q      <= 10'd0;
            by_q      <= 10'd0;
            dx_q      <= 1'b1;
            dy_q      <= 1'b1;
        end else begin
            mode_q    <= mode_d;
            pending_q <= pending_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
        end
    end

    // Next-state: requests are latched and committed only at frame start;
    // a request arriving on the tick itself is honoured on that tick.
    always_comb begin
        mode_d    = mode_q;
        pending_d = pending_q;
        bx_d      = bx_q;
        by_d      = by_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        if (frame_tick_q) begin
            pending_d    = 1'b0;
            {dx_d, bx_d} = step_axis(bx_q, dx_q, X_LIMIT);
            {dy_d, by_d} = step_axis(by_q, dy_q, Y_LIMIT);
            if (pending_q || mode_next) begin
                case (mode_q)
                    MODE_BARS:  mode_d = MODE_GRID;
                    MODE_GRID:  mode_d = MODE_BOX;
                    MODE_BOX:   mode_d = MODE_SOLID;
                    MODE_SOLID: mode_d = MODE_BARS;
                    default:    mode_d = MODE_BARS;
                endcase
            end else begin
                mode_d = mode_q;
            end
        end else if (mode_next) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    // Output decode: pixel colour for the current mode, blanked outside the active area.
    always_comb begin
        rgb_s    = 12'h000;
        in_box_s = ({1'b0, x_q} >= {1'b0, bx_q}) && ({1'b0, x_q} < ({1'b0, bx_q} + SIZE)) &&
                   ({1'b0, y_q} >= {1'b0, by_q}) && ({1'b0, y_q} < ({1'b0, by_q} + SIZE));
        if (bright_q) begin
            case (mode_q)
                MODE_BARS: rgb_s = bar_colour(x_q);
                MODE_GRID: begin
                    if ((x_q[4:0] == 5'd0) || (y_q[4:0] == 5'd0) ||
                        (x_q == 10'd639) || (y_q == 10'd479)) begin
                        rgb_s = 12'hFFF;
                    end else begin
                        rgb_s = 12'h000;
                    end
                end
                MODE_BOX: begin
                    if (in_box_s) begin
                        rgb_s = 12'hFFF;
                    end else begin
                        rgb_s = 12'h008;
                    end
                end
                MODE_SOLID: rgb_s = 12'h888;
                default:    rgb_s = 12'h000;
            endcase
        end else begin
            rgb_s = 12'h000;
        end
    end

    // Stage 2: register colour and syncs so all outputs share the same latency.
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            rgb_q <= 12'h000;
            hs2_q <= 1'b1;
            vs2_q <= 1'b1;
        end else begin
            rgb_q <= rgb_s;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
        end
    end

    assign red        = rgb_q[11:8];
    assign green      = rgb_q[7:4];
    assign blue       = rgb_q[3:0];
    assign h_sync     = hs2_q;
    assign v_sync     = vs2_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: reset values, bar colours, blanking,
// sync latency, mode sequencing, box bounce and asynchronous reset.
module tb_vga_pattern_gen;

    logic       clk_25 = 1'b0;
    logic       reset;
    logic [9:0] h_count, v_count;
    logic       bright, h_sync_in, v_sync_in, mode_next;
    logic [3:0] red, green, blue;
    logic       h_sync, v_sync, frame_tick;

    int checks   = 0;
    int failures = 0;
    int nticks   = 0;

    vga_pattern_gen #(.BOX_SIZE(32), .BOX_STEP(2)) dut (
        .clk_25    (clk_25),
        .reset     (reset),
        .h_count   (h_count),
        .v_count   (v_count),
        .bright    (bright),
        .h_sync_in (h_sync_in),
        .v_sync_in (v_sync_in),
        .mode_next (mode_next),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .h_sync    (h_sync),
        .v_sync    (v_sync),
        .frame_tick(frame_tick)
    );

    // 25 MHz pixel clock
    always #20 clk_25 = ~clk_25;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Box position after n frame ticks from reset: 2-pixel steps bouncing between 0 and lim.
    function automatic int tri_pos(input int n, input int lim);
        int m;
        m = n % lim;
        return (m <= lim / 2) ? 2 * m : 2 * (lim - m);
    endfunction

    // Drive one pixel, sample RGB two clocks later, then return to idle.
    task automatic pix(input int h, input int v, input logic b, input string tag, input logic [11:0] exp);
        @(negedge clk_25);
        h_count = 10'(h);
        v_count = 10'(v);
        bright  = b;
        repeat (2) @(negedge clk_25);
        check_eq(tag, {20'd0, red, green, blue}, {20'd0, exp});
        h_count = 10'd1;
        v_count = 10'd0;
        bright  = 1'b0;
    endtask

    task automatic apix(input int x, input int y, input string tag, input logic [11:0] exp);
        pix(x + 160, y + 41, 1'b1, tag, exp);
    endtask

    // Present the frame origin; optionally raise mode_next on the tick cycle.
    task automatic frame(input logic mn_on_tick);
        @(negedge clk_25);
        h_count = 10'd0;
        v_count = 10'd0;
        bright  = 1'b0;
        @(negedge clk_25);
        h_count = 10'd1;
        check_eq("frame_tick_hi", {31'd0, frame_tick}, 32'd1);
        mode_next = mn_on_tick;
        @(negedge clk_25);
        mode_next = 1'b0;
        check_eq("frame_tick_lo", {31'd0, frame_tick}, 32'd0);
        nticks++;
    endtask

    task automatic pulse_next();
        @(negedge clk_25);
        mode_next = 1'b1;
        @(negedge clk_25);
        mode_next = 1'b0;
    endtask

    logic [11:0] bar_exp [10];
    int          bar_x   [10];
    int          first_low, low_cnt, bx, by;

    initial begin
        bar_x   = '{0, 79, 80, 160, 240, 320, 400, 480, 560, 639};
        bar_exp = '{12'hFFF, 12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                    12'hF0F, 12'hF00, 12'h00F, 12'h000, 12'h000};

        reset     = 1'b1;
        h_count   = 10'd1;
        v_count   = 10'd0;
        bright    = 1'b0;
        h_sync_in = 1'b1;
        v_sync_in = 1'b1;
        mode_next = 1'b0;
        #5;
        check_eq("rst_rgb", {20'd0, red, green, blue}, 32'h000);
        check_eq("rst_hsync", {31'd0, h_sync}, 32'd1);
        check_eq("rst_vsync", {31'd0, v_sync}, 32'd1);
        check_eq("rst_ftick", {31'd0, frame_tick}, 32'd0);
        repeat (2) @(negedge clk_25);
        reset = 1'b0;

        // Colour bars including bar edges
        for (int i = 0; i < 10; i++) begin
            apix(bar_x[i], 0, $sformatf("bars_x%0d", bar_x[i]), bar_exp[i]);
        end
        pix(300, 100, 1'b0, "dark_bars", 12'h000);

        // h_sync: 96 low cycles, delayed by two clocks
        first_low = -1;
        low_cnt   = 0;
        @(negedge clk_25);
        h_sync_in = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk_25);
            if (!h_sync) begin
                low_cnt++;
                if (first_low < 0) first_low = i;
            end
            if (i == 96) h_sync_in = 1'b1;
        end
        check_eq("hsync_delay", 32'(first_low), 32'd2);
        check_eq("hsync_width", 32'(low_cnt), 32'd96);

        // v_sync latency
        @(negedge clk_25);
        v_sync_in = 1'b0;
        @(negedge clk_25);
        v_sync_in = 1'b1;
        check_eq("vsync_lat1", {31'd0, v_sync}, 32'd1);
        @(negedge clk_25);
        check_eq("vsync_lat2", {31'd0, v_sync}, 32'd0);
        @(negedge clk_25);
        check_eq("vsync_back", {31'd0, v_sync}, 32'd1);

        // Three requests in one frame advance only to GRID
        pulse_next();
        pulse_next();
        pulse_next();
        apix(33, 5, "bars_before_tick", 12'hFFF);
        frame(1'b0);
        apix(32, 5, "grid_x32", 12'hFFF);
        apix(33, 5, "grid_x33", 12'h000);
        apix(639, 100, "grid_x639", 12'hFFF);
        apix(100, 479, "grid_y479", 12'hFFF);
        apix(100, 100, "grid_blank", 12'h000);
        pix(192, 46, 1'b0, "dark_grid", 12'h000);
        frame(1'b0);
        apix(33, 5, "grid_held", 12'h000);

        // Request coincident with the tick: advance to BOX, nothing left pending
        frame(1'b1);
        frame(1'b0);
        bx = tri_pos(nticks, 608);
        by = tri_pos(nticks, 448);
        apix(bx, by, "box_in", 12'hFFF);
        apix(bx + 32, by, "box_right_out", 12'h008);
        apix(bx, by + 32, "box_below_out", 12'h008);

        // Bounce off the right edge
        while (nticks < 304) frame(1'b0);
        by = tri_pos(nticks, 448);
        apix(608, by, "box_at_limit", 12'hFFF);
        apix(639, by, "box_last_col", 12'hFFF);
        apix(607, by, "box_left_out", 12'h008);
        frame(1'b0);
        by = tri_pos(nticks, 448);
        apix(606, by, "box_back_606", 12'hFFF);
        apix(637, by, "box_back_637", 12'hFFF);
        apix(638, by, "box_back_638", 12'h008);
        apix(606, by + 32, "box_back_below", 12'h008);

        // Asynchronous reset mid-line in BOX mode
        @(negedge clk_25);
        h_count   = 10'(160 + 606);
        v_count   = 10'(41 + by);
        bright    = 1'b1;
        h_sync_in = 1'b0;
        v_sync_in = 1'b0;
        repeat (2) @(negedge clk_25);
        check_eq("pre_rst_rgb", {20'd0, red, green, blue}, 32'hFFF);
        check_eq("pre_rst_hsync", {31'd0, h_sync}, 32'd0);
        #5;
        reset = 1'b1;
        #1;
        check_eq("async_rst_rgb", {20'd0, red, green, blue}, 32'h000);
        check_eq("async_rst_hsync", {31'd0, h_sync}, 32'd1);
        check_eq("async_rst_vsync", {31'd0, v_sync}, 32'd1);
        h_sync_in = 1'b1;
        v_sync_in = 1'b1;
        h_count   = 10'd1;
        v_count   = 10'd0;
        bright    = 1'b0;
        @(negedge clk_25);
        reset  = 1'b0;
        nticks = 0;
        apix(80, 10, "post_rst_bars", 12'hFF0);
        pulse_next();
        frame(1'b0);
        pulse_next();
        frame(1'b0);
        apix(4, 4, "post_rst_box_in", 12'hFFF);
        apix(3, 4, "post_rst_box_left", 12'h008);
        apix(36, 4, "post_rst_box_right", 12'h008);
        apix(35, 36, "post_rst_box_below", 12'h008);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 Parameter: BOX_SIZE, default 32, side of the moving box in pixels.
REQ-002 Parameter: BOX_STEP, default 2, box displacement per frame per axis in pixels.
REQ-003 Port clk_25 input 1: 25 MHz pixel clock; all state on rising edge.
REQ-004 Port reset input 1: asynchronous, active-high reset.
REQ-005 Port h_count input 10: horizontal position from timing stage; active columns 160..799.
REQ-006 Port v_count input 10: vertical position from timing stage; active lines 41..520.
REQ-007 Port bright input 1: high while h_count/v_count are inside the active area.
REQ-008 Port h_sync_in input 1: horizontal sync from timing stage, active-low.
REQ-009 Port v_sync_in input 1: vertical sync from timing stage, active-low.
REQ-010 Port mode_next input 1: single-cycle request to advance pattern mode.
REQ-011 Port red, green, blue output 4 each: pixel colour.
REQ-012 Port h_sync, v_sync output 1 each: syncs delayed to align with RGB.
REQ-013 Port frame_tick output 1: one-cycle pulse at frame start.

Function
REQ-014 Pipeline: stage 1 registers h_count, v_count, bright, syncs and computes x = h_count-160, y = v_count-41 (10-bit); stage 2 registers RGB and syncs; total latency 2 cycles, identical for RGB, h_sync, v_sync.
REQ-015 RGB SHALL be 0x0/0x0/0x0 whenever the stage-1 bright is low, regardless of mode.
REQ-016 frame_tick SHALL pulse for exactly one cycle, one cycle after input h_count==0 and v_count==0 is sampled.
REQ-017 Mode FSM states BARS -> GRID -> BOX -> SOLID -> BARS; 2-bit encoding 0..3.
REQ-018 mode_next sets a pending flag; mode advances by exactly one state on the next frame_tick and pending clears; multiple pulses within one frame advance only once.
REQ-019 mode_next coincident with frame_tick: advance on that tick, pending not left set.
REQ-020 BARS: eight 80-pixel vertical bars by x[9:7..] = x/80, colours in order white FFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000.
REQ-021 GRID: FFF when x[4:0]==0 or y[4:0]==0 or x==639 or y==479, else 000.
REQ-022 BOX: FFF when bx <= x < bx+BOX_SIZE and by <= y < by+BOX_SIZE, else background 008.
REQ-023 Box position bx (0..640-BOX_SIZE), by (0..480-BOX_SIZE) and direction bits dx, dy SHALL update only on frame_tick, in every mode.
REQ-024 Box edge: if the next position would pass a limit, position SHALL clamp to that limit and the direction bit SHALL invert in the same update; no frame shows the box outside the active area.
REQ-025 SOLID: uniform colour 888 across the active area.
REQ-026 Mode and box position SHALL not change mid-frame; a frame renders with one consistent mode and box position.
REQ-027 Arithmetic on x, y, bx, by SHALL be unsigned 10-bit with no wrap for any legal input; inputs outside active ranges are masked by bright.

Reset
REQ-028 On reset: red/green/blue 0, h_sync 1, v_sync 1, frame_tick 0, mode BARS, pending 0, bx 0, by 0, dx +, dy +, all pipeline registers cleared (syncs to 1).
REQ-029 Reset asserted mid-frame SHALL force the reset values immediately, independent of clk_25; operation resumes with the first rising edge after deassertion.

Verification
REQ-030 Reset then drive h_count=160, v_count=41, bright=1 -> two cycles later RGB = FFF (BARS bar 0); h_count=240 -> FF0.
REQ-031 Drive h_sync_in low for 96 cycles -> h_sync low for exactly 96 cycles, delayed by 2 cycles.
REQ-032 Three mode_next pulses within one frame -> after next frame_tick mode GRID only; pixel x=32,y=5 -> FFF, x=33,y=5 -> 000.
REQ-033 Mode BOX, run 305 frames -> bx reaches 608, dx inverts, following frame bx=606; box never rendered past x=639.
REQ-034 bright=0 with any mode and counts -> RGB 000 two cycles later.
REQ-035 Assert reset mid-line in BOX mode -> outputs 000, syncs 1 immediately; mode BARS and bx=by=0 after release.
